// File: rtl/gin_pe_fifo.sv
// Per-PE first-word-fall-through input buffer behind the GIN multicast controller.
// Define GIN_PE_FIFO_COUNT_EN to expose count_out and almost_full.
module gin_pe_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AF_THRESH  = DEPTH - 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    enable_in,
    output logic                    ready_out,
    input  logic                    pop_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
`ifdef GIN_PE_FIFO_COUNT_EN
    output logic [$clog2(DEPTH):0]  count_out,
    output logic                    almost_full,
`endif
    output logic                    overflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Reject configurations the pointer arithmetic cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_THRESH == 0 || AF_THRESH > DEPTH) begin : g_bad_param
        $error("gin_pe_fifo: DEPTH must be a power of two >= 2 and 1 <= AF_THRESH <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = enable_in && !full;
    assign pop   = pop_in && !empty;

    // Flags and head word depend only on registered state.
    assign ready_out = !full;
    assign valid_out = !empty;
    assign data_out  = empty ? '0 : mem[rd_ptr];

`ifdef GIN_PE_FIFO_COUNT_EN
    assign count_out   = count;
    assign almost_full = (count >= CNT_W'(AF_THRESH));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            // A dropped push is sticky until reset.
            if (enable_in && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Storage is not cleared; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: doc/gin_pe_fifo.md
Name: gin_pe_fifo

Overview:
- Per-PE input buffer directly downstream of the GIN multicast controller.
- Accepts words qualified by the controller's enable and returns back-pressure to the controller's ready input.
- Presents first-word-fall-through data to the PE datapath with a valid/pop interface.
- One instance per PE per data type (ifmap, filter, psum).

Parameters:
- DATA_WIDTH, 64: width of each buffered word; matches the multicast controller data width.
- DEPTH, 4: number of entries. Must be a power of two, >= 2.
- AF_THRESH, DEPTH-1: occupancy at or above which almost_full asserts (optional feature only).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- data_in  input  DATA_WIDTH  word from multicast controller data_out
- enable_in  input  1  push strobe from multicast controller enable_out
- ready_out  output  1  to multicast controller ready_in; 1 = space available
- pop_in  input  1  PE consumes head word this cycle
- data_out  output  DATA_WIDTH  head word; zero when empty
- valid_out  output  1  FIFO non-empty
- overflow_err  output  1  sticky: push attempted while full
- count_out  output  $clog2(DEPTH)+1  occupancy (optional feature only)
- almost_full  output  1  count_out >= AF_THRESH (optional feature only)

Behaviour:
- Storage: DEPTH-entry register array; rd_ptr and wr_ptr are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- full = (count == DEPTH); empty = (count == 0). Both derive from registered state only. No combinational path from enable_in or pop_in to ready_out or valid_out.
- ready_out = !full. valid_out = !empty. data_out = mem[rd_ptr] when !empty, else all zeros.
- Push: enable_in && !full writes data_in at wr_ptr and increments wr_ptr.
- Push while full: word dropped, pointers unchanged, overflow_err set to 1. overflow_err stays 1 until reset.
- Pop: pop_in && !empty increments rd_ptr. Pop while empty is ignored, with no error.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - Full: pop accepted, push dropped and flagged as overflow. The upstream controller cannot legally push then because ready_out=0.
  - Empty: push accepted, pop ignored.
- Latency: a word pushed in cycle N appears on data_out with valid_out=1 in cycle N+1. A pop in cycle N exposes the next word (or zeros/valid 0) in cycle N+1.
- Ordering: strict FIFO; no reordering or duplication.
- Reset (takes priority over push/pop in the same cycle):
  - rd_ptr = wr_ptr = count = 0.
  - ready_out = 1, valid_out = 0, data_out = 0, overflow_err = 0.
  - Array contents need not be cleared.
- Reset mid-operation: all buffered words are discarded; the first post-reset push behaves as into an empty FIFO.

Optional Feature:
- Macro: GIN_PE_FIFO_COUNT_EN.
- Defined:
  - count_out drives the internal count, reset value 0.
  - almost_full = (count >= AF_THRESH), reset value 0, registered-state-derived.
- Not defined:
  - count_out and almost_full ports are absent.
  - AF_THRESH is unused.
  - Core FIFO behaviour is identical.

Test Plan:
1. Reset, then push 0xA5A5 at cycle 1 with no pop -> cycle 2: valid_out=1, data_out=0xA5A5, ready_out=1.
2. DEPTH=4: push 1,2,3,4 on consecutive cycles -> ready_out=0 after the 4th. Push 5 while full -> overflow_err=1 and stays 1. Pop four times -> data_out 1,2,3,4 in order, then valid_out=0 and data_out=0.
3. FIFO holding 2 words, push and pop in the same cycle for 10 cycles -> count stays 2, output order matches input order, overflow_err=0.
4. Full FIFO, pop_in=1 and enable_in=1 in the same cycle -> head popped, push dropped, overflow_err=1, ready_out=1 next cycle.
5. Empty FIFO, pop_in=1 for 3 cycles -> no state change, valid_out=0, overflow_err=0. Then assert reset with 3 words buffered -> next cycle valid_out=0, ready_out=1.
6. With GIN_PE_FIFO_COUNT_EN, DEPTH=4, AF_THRESH=3: push 3 words -> count_out=3 and almost_full=1. Pop 1 -> count_out=2 and almost_full=0.
